seq_divider: RTL and testbench

- Multi-cycle 32-bit integer divider for the ALU's long-latency path. It performs restoring shift-subtract division, one quotient bit per clock.
- Companion to the combinational adder: each iteration is a trial subtraction (A + ~B + 1), and the carry out decides the quotient bit.
- Supports signed and unsigned operands and presents a start/busy/done handshake to the control unit.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_trial_sub.sv | 13 +
 rtl/seq_divider.sv | 179 +++++++++++++++++
 tb/tb_seq_divider.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encoding.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider_trial_sub.sv
// Combinational trial subtraction a - b computed as a + ~b + 1; carry out means no borrow.
module div_trial_sub #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         no_borrow_o
);

    assign {no_borrow_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + (N+1)'(1);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed/unsigned,
// with start/busy/done handshake and divide-by-zero / signed-overflow traps.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned       CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]  MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_IT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dzf_q, dzf_d;
    logic             ovf_q, ovf_d;

    logic             dz_c;
    logic             ov_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_diff_c;
    logic             no_borrow_c;
    logic             unused_diff_msb;

    assign dz_c = (divisor == '0);
    assign ov_c = is_signed && (dividend == MIN_VAL) && (divisor == '1);

    // Next partial remainder candidate: {prem, dividend} shifted left by one
    assign shifted_c = {prem_q, dq_q[WIDTH-1]};

    div_trial_sub #(.N(WIDTH + 1)) u_trial (
        .a_i         (shifted_c),
        .b_i         ({1'b0, dvs_q}),
        .diff_o      (trial_diff_c),
        .no_borrow_o (no_borrow_c)
    );

    // A successful trial is always below the divisor, so its MSB is never needed
    assign unused_diff_msb = trial_diff_c[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dzf_d   = dzf_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    dzf_d  = 1'b0;
                    ovf_d  = 1'b0;
                    dz_d   = dz_c;
                    ov_d   = ov_c;
                    qneg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d = is_signed && dividend[WIDTH-1];
                    // Divide-by-zero keeps the raw dividend here as its remainder
                    dq_d   = (is_signed && dividend[WIDTH-1] && !dz_c)
                             ? (~dividend + WIDTH'(1)) : dividend;
                    dvs_d  = (is_signed && divisor[WIDTH-1])
                             ? (~divisor + WIDTH'(1)) : divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    state_d = (dz_c || ov_c) ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                prem_d = no_borrow_c ? trial_diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];
                dq_d   = {dq_q[WIDTH-2:0], no_borrow_c};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                done_d  = 1'b1;
                state_d = ST_DONE;
                if (dz_q) begin
                    quot_d = '1;
                    rem_d  = dq_q;
                    dzf_d  = 1'b1;
                end else if (ov_q) begin
                    quot_d = MIN_VAL;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = qneg_q ? (~dq_q + WIDTH'(1)) : dq_q;
                    rem_d  = rneg_q ? (~prem_q + WIDTH'(1)) : prem_q;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dzf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dzf_q   <= dzf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dzf_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes reference results, a monitor checks each done pulse.
module tb_seq_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_pass;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Reference: integer division truncating toward zero, plus the two traps
    function automatic exp_t model(input string name, input bit s, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sb;
        e.name = name;
        e.dz   = 1'b0;
        e.ov   = 1'b0;
        e.lat  = 34;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.ov = 1'b1; e.lat = 2;
        end else if (s) begin
            sa = a;
            sb = b;
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: compares each done pulse against the oldest expected result
    initial begin
        int  busy_cnt;
        bit  prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    check("done_one_cycle", 64'(done), 64'd0);
                    check("busy_drop_after_done", 64'(busy), 64'd0);
                end
                if (busy) busy_cnt++;
                else busy_cnt = 0;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, "_quotient"}, 64'(quotient), 64'(e.q));
                        check({e.name, "_remainder"}, 64'(remainder), 64'(e.r));
                        check({e.name, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
                        check({e.name, "_overflow"}, 64'(overflow), 64'(e.ov));
                        check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat));
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic run_op(input string name, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit repulse);
        exp_t e;
        bit   got_done;
        int   k;
        @(negedge clk);
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        e = model(name, s, a, b);
        exp_q.push_back(e);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        got_done  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            start = repulse && (i == 10);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done_seen"}, 64'(got_done), 64'd1);
        if (!got_done) exp_q.delete();
        if (repulse) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        repeat (2) @(negedge clk);
        check({name, "_idle_after"}, 64'(busy), 64'd0);
        check({name, "_held_q"}, 64'(quotient), 64'(e.q));
        check({name, "_held_r"}, 64'(remainder), 64'(e.r));
        check({name, "_held_flags"}, 64'({div_by_zero, overflow}), 64'({e.dz, e.ov}));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_done"}, 64'(done), 64'd0);
        check({name, "_q"}, 64'(quotient), 64'd0);
        check({name, "_r"}, 64'(remainder), 64'd0);
        check({name, "_flags"}, 64'({div_by_zero, overflow}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          mode;
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_op("u_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("u_div0", 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        run_op("s_div0", 1'b1, 32'h0000_1234, 32'd0, 1'b0);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("u_max_1_repulse", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);

        // Reset during the 10th CALC cycle discards the operation
        @(negedge clk);
        is_signed = 1'b0;
        dividend  = 32'd5000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("mid_reset");
        repeat (3) @(negedge clk);
        check("mid_reset_stays_idle", 64'(busy), 64'd0);
        run_op("u_1000_10", 1'b0, 32'd1000, 32'd10, 1'b0);

        // Reset wins over a simultaneous start
        @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check_all_zero("rst_and_start");
        @(negedge clk);
        check("rst_and_start_idle", 64'(busy), 64'd0);

        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 5));
            s    = 1'($urandom);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'($urandom_range(0, 1000)); b = b | 32'h0001_0000; end
                3: begin a = 32'h8000_0000; b = (n % 2 == 0) ? 32'hFFFF_FFFF : b; end
                default: ;
            endcase
            run_op("rand", s, a, b, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
